// File: rtl/smem_violation_reset_ctrl.sv
// ---------------------------------------------------------------------------
// smem_violation_reset_ctrl
//
// Central reset sequencer for the secure-memory protection monitors.
// When any monitor raises a violation while idle, the controller latches
// the highest-priority cause, counts the event and holds sys_reset high
// for HOLD_CYCLES cycles. It then waits up to WAIT_MAX cycles for the CPU
// to fetch the reset vector (pc == RESET_HANDLER). If the fetch never
// comes, reset is asserted again without counting a new event.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pc           current CPU program counter
//   viol         level violation requests, bit 0 = highest priority
//   cause_clr    single-cycle clear of the latched cause (IDLE only)
//   sys_reset    registered system reset request to the CPU core
//   busy         high whenever the sequencer is not idle
//   cause        one-hot latched cause, zero when cause_valid is low
//   cause_valid  a cause is latched and not yet cleared
//   viol_count   saturating count of accepted violation events
// ---------------------------------------------------------------------------
module smem_violation_reset_ctrl #(
    parameter int          NUM_SRC       = 4,
    parameter int          HOLD_CYCLES   = 4,
    parameter int          WAIT_MAX      = 16,
    parameter int          CNT_W         = 8,
    parameter logic [15:0] RESET_HANDLER = 16'hfffe
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        pc,
    input  logic [NUM_SRC-1:0] viol,
    input  logic               cause_clr,
    output logic               sys_reset,
    output logic               busy,
    output logic [NUM_SRC-1:0] cause,
    output logic               cause_valid,
    output logic [CNT_W-1:0]   viol_count
);

    // Both timers share one width, wide enough for the larger reload value.
    localparam int MAX_CYC = (HOLD_CYCLES > WAIT_MAX) ? HOLD_CYCLES : WAIT_MAX;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_VEC = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TW-1:0]      hold_cnt;
    logic [TW-1:0]      wait_cnt;
    logic               accept;
    logic [NUM_SRC-1:0] first_viol;

    // Violations are only accepted while idle; HOLD and WAIT_VEC ignore them.
    assign accept = (state == IDLE) && (|viol);

    // Isolate the lowest-index set bit: two's complement trick keeps only it.
    assign first_viol = viol & (~viol + NUM_SRC'(1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (|viol) state_next = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) state_next = WAIT_VEC;
            end
            WAIT_VEC: begin
                // The vector fetch wins over a simultaneous timeout.
                if (pc == RESET_HANDLER)  state_next = IDLE;
                else if (wait_cnt == '0)  state_next = HOLD;
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy = (state != IDLE);
    end

    // -----------------------------------------------------------------------
    // Timers, reset output, cause latch and event counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sys_reset   <= 1'b0;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            cause       <= '0;
            cause_valid <= 1'b0;
            viol_count  <= '0;
        end else begin
            // Registered so sys_reset has no combinational path from inputs.
            sys_reset <= (state_next == HOLD);

            // Hold timer loads on every entry to HOLD, including re-assertion
            // after a wait timeout.
            if (state != HOLD && state_next == HOLD) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - TW'(1);
            end

            if (state == HOLD && state_next == WAIT_VEC) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT_VEC && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - TW'(1);
            end

            if (accept && viol_count != {CNT_W{1'b1}}) begin
                viol_count <= viol_count + CNT_W'(1);
            end

            // First cause is sticky; a same-cycle clear lets the new one in.
            if (accept) begin
                if (!cause_valid || cause_clr) begin
                    cause       <= first_viol;
                    cause_valid <= 1'b1;
                end
            end else if (state == IDLE && cause_clr) begin
                cause       <= '0;
                cause_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_smem_violation_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smem_violation_reset_ctrl
//
// Drives a default-parameter controller and a CNT_W=2 copy from the same
// inputs. Expectations come from a cycle-level behavioural model expressed
// as "reset cycles remaining" and "cycles waited", plus directed constants.
// ---------------------------------------------------------------------------
module tb_smem_violation_reset_ctrl;

    localparam int          HC = 4;
    localparam int          WM = 16;
    localparam logic [15:0] HANDLER = 16'hfffe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] pc = 16'h0000;
    logic [3:0]  viol = 4'b0000;
    logic        cause_clr = 1'b0;

    logic        sys_reset;
    logic        busy;
    logic [3:0]  cause;
    logic        cause_valid;
    logic [7:0]  viol_count;

    logic        s_sys_reset;
    logic        s_busy;
    logic [3:0]  s_cause;
    logic        s_cause_valid;
    logic [1:0]  s_viol_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: 0 idle, 1 reset held, 2 waiting for vector fetch.
    int         m_mode = 0;
    int         m_hold_left = 0;
    int         m_waited = 0;
    int         m_events = 0;
    logic [3:0] m_cause = 4'b0000;
    logic       m_cv = 1'b0;

    smem_violation_reset_ctrl dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .viol(viol), .cause_clr(cause_clr),
        .sys_reset(sys_reset), .busy(busy), .cause(cause),
        .cause_valid(cause_valid), .viol_count(viol_count)
    );

    smem_violation_reset_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .pc(pc), .viol(viol), .cause_clr(cause_clr),
        .sys_reset(s_sys_reset), .busy(s_busy), .cause(s_cause),
        .cause_valid(s_cause_valid), .viol_count(s_viol_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'(1) << i;
        end
        return 4'b0000;
    endfunction

    function automatic int exp_count();
        return (m_events > 255) ? 255 : m_events;
    endfunction

    function automatic int exp_sat();
        return (m_events > 3) ? 3 : m_events;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_hold_left = 0; m_waited = 0; m_events = 0;
        m_cause = 4'b0000; m_cv = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        case (m_mode)
            0: begin
                if (viol != 4'b0000) begin
                    m_events++;
                    if (!m_cv || cause_clr) begin
                        m_cause = first_set(viol);
                        m_cv = 1'b1;
                    end
                    m_mode = 1;
                    m_hold_left = HC;
                end else if (cause_clr) begin
                    m_cause = 4'b0000;
                    m_cv = 1'b0;
                end
            end
            1: begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_mode = 2;
                    m_waited = 0;
                end
            end
            default: begin
                if (pc == HANDLER) m_mode = 0;
                else if (m_waited == WM - 1) begin
                    m_mode = 1;
                    m_hold_left = HC;
                end else m_waited++;
            end
        endcase
    endtask

    // One clock: inputs are stable at the rising edge; return on the falling
    // edge so outputs are sampled well away from the active edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Steer the model (and DUT) back to idle with no inputs asserted.
    task automatic go_idle();
        viol = 4'b0000;
        cause_clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_mode == 0) break;
            pc = (m_mode == 2) ? HANDLER : 16'h0000;
            tick();
        end
        pc = 16'h0000;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #10;
        n_cmp++; if (sys_reset !== 1'b0) begin n_bad++; $display("FAIL reset_sys_reset got %b want 0", sys_reset); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (cause !== 4'b0000) begin n_bad++; $display("FAIL reset_cause got %b want 0000", cause); end
        n_cmp++; if (cause_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cause_valid got %b want 0", cause_valid); end
        n_cmp++; if (viol_count !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", viol_count); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_priority();
        viol = 4'b0110;
        tick();
        viol = 4'b0000;
        n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL prio_latency got %b want 1", sys_reset); end
        n_cmp++; if (cause !== 4'b0010) begin n_bad++; $display("FAIL prio_cause got %b want 0010", cause); end
        n_cmp++; if (cause_valid !== 1'b1) begin n_bad++; $display("FAIL prio_valid got %b want 1", cause_valid); end
        n_cmp++; if (viol_count !== 8'd1) begin n_bad++; $display("FAIL prio_count got %0d want 1", viol_count); end
        for (int i = 1; i < HC; i++) begin
            tick();
            n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL prio_hold_%0d got %b want 1", i, sys_reset); end
        end
        tick();
        n_cmp++; if (sys_reset !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL prio_wait_entry got rst=%b busy=%b want rst=0 busy=1", sys_reset, busy);
        end
    endtask

    task automatic test_vector_fetch();
        pc = 16'h1234;
        tick();
        pc = HANDLER;
        tick();
        pc = 16'h0000;
        n_cmp++; if (busy !== 1'b0 || sys_reset !== 1'b0) begin
            n_bad++; $display("FAIL fetch_idle got busy=%b rst=%b want 0 0", busy, sys_reset);
        end
        viol = 4'b1000;
        tick();
        viol = 4'b0000;
        n_cmp++; if (cause !== 4'b0010) begin n_bad++; $display("FAIL fetch_sticky_cause got %b want 0010", cause); end
        n_cmp++; if (viol_count !== 8'd2) begin n_bad++; $display("FAIL fetch_count got %0d want 2", viol_count); end
        go_idle();
    endtask

    task automatic test_timeout();
        viol = 4'b0001;
        tick();
        viol = 4'b0000;
        pc = 16'h1234;
        repeat (HC) tick();
        for (int i = 1; i < WM; i++) begin
            tick();
            n_cmp++; if (sys_reset !== 1'b0) begin n_bad++; $display("FAIL timeout_wait_%0d got %b want 0", i, sys_reset); end
        end
        tick();
        n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL timeout_reassert got %b want 1", sys_reset); end
        n_cmp++; if (viol_count !== 8'd3) begin n_bad++; $display("FAIL timeout_count got %0d want 3", viol_count); end
        for (int i = 1; i < HC; i++) begin
            tick();
            n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL timeout_hold_%0d got %b want 1", i, sys_reset); end
        end
        tick();
        repeat (WM - 1) tick();
        pc = HANDLER;
        tick();
        pc = 16'h0000;
        n_cmp++; if (busy !== 1'b0 || sys_reset !== 1'b0) begin
            n_bad++; $display("FAIL timeout_last_fetch got busy=%b rst=%b want 0 0", busy, sys_reset);
        end
        n_cmp++; if (cause !== 4'b0010) begin n_bad++; $display("FAIL timeout_cause got %b want 0010", cause); end
    endtask

    task automatic test_cause_clear();
        cause_clr = 1'b1;
        viol = 4'b0100;
        tick();
        cause_clr = 1'b0;
        viol = 4'b0000;
        n_cmp++; if (cause !== 4'b0100 || cause_valid !== 1'b1) begin
            n_bad++; $display("FAIL clr_with_viol got %b/%b want 0100/1", cause, cause_valid);
        end
        tick();
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        n_cmp++; if (cause !== 4'b0100 || cause_valid !== 1'b1) begin
            n_bad++; $display("FAIL clr_in_hold got %b/%b want 0100/1", cause, cause_valid);
        end
        go_idle();
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        n_cmp++; if (cause !== 4'b0000 || cause_valid !== 1'b0) begin
            n_bad++; $display("FAIL clr_alone got %b/%b want 0000/0", cause, cause_valid);
        end
        n_cmp++; if (viol_count !== 8'd4) begin n_bad++; $display("FAIL clr_count got %0d want 4", viol_count); end
    endtask

    task automatic test_saturation();
        #2 reset_n = 1'b0;
        #2 model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            viol = 4'($urandom_range(1, 15));
            tick();
            viol = 4'b0000;
            n_cmp++; if (s_viol_count !== 2'((e > 3) ? 3 : e)) begin
                n_bad++; $display("FAIL sat_count_%0d got %0d want %0d", e, s_viol_count, (e > 3) ? 3 : e);
            end
            n_cmp++; if (viol_count !== 8'(e)) begin
                n_bad++; $display("FAIL sat_wide_count_%0d got %0d want %0d", e, viol_count, e);
            end
            go_idle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            viol = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cause_clr = ($urandom_range(0, 4) == 0);
            pc = ($urandom_range(0, 5) == 0) ? HANDLER : 16'($urandom);
            tick();
            n_cmp++; if (sys_reset !== (m_mode == 1) || busy !== (m_mode != 0)) begin
                n_bad++; $display("FAIL rand_ctrl cyc %0d got rst=%b busy=%b want rst=%b busy=%b",
                                  c, sys_reset, busy, m_mode == 1, m_mode != 0);
            end
            n_cmp++; if (cause !== m_cause || cause_valid !== m_cv) begin
                n_bad++; $display("FAIL rand_cause cyc %0d got %b/%b want %b/%b", c, cause, cause_valid, m_cause, m_cv);
            end
            n_cmp++; if (viol_count !== 8'(exp_count()) || s_viol_count !== 2'(exp_sat())) begin
                n_bad++; $display("FAIL rand_count cyc %0d got %0d/%0d want %0d/%0d",
                                  c, viol_count, s_viol_count, exp_count(), exp_sat());
            end
            n_cmp++; if (s_sys_reset !== (m_mode == 1) || s_busy !== (m_mode != 0) ||
                         s_cause !== m_cause || s_cause_valid !== m_cv) begin
                n_bad++; $display("FAIL rand_sat_ctrl cyc %0d got rst=%b busy=%b cause=%b/%b", c, s_sys_reset, s_busy, s_cause, s_cause_valid);
            end
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        viol = 4'b0010;
        tick();
        viol = 4'b0000;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (sys_reset !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL async_ctrl got rst=%b busy=%b want 0 0", sys_reset, busy);
        end
        n_cmp++; if (viol_count !== 8'd0 || cause_valid !== 1'b0 || cause !== 4'b0000) begin
            n_bad++; $display("FAIL async_state got cnt=%0d valid=%b cause=%b want 0 0 0000", viol_count, cause_valid, cause);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0 || sys_reset !== 1'b0) begin
            n_bad++; $display("FAIL async_release got busy=%b rst=%b want 0 0", busy, sys_reset);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_vector_fetch();
        test_timeout();
        test_cause_clear();
        test_saturation();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
